// File: rtl/uart_tx_mmio_pkg.sv
// uart_tx_mmio_pkg: shared constants for the memory-mapped UART transmitter.
//   FSM state encodings and the default store address that enqueues a byte;
//   the address is also referenced by the data-memory address decode.
package uart_tx_mmio_pkg;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] START = 2'd1;
   localparam logic [1:0] DATA  = 2'd2;
   localparam logic [1:0] STOP  = 2'd3;

   localparam logic [31:0] UART_TX_ADDR = 32'h0000_8000;

endpackage

// File: rtl/uart_tx_mmio_fifo.sv
// sync_fifo: single-clock FIFO with a separately tracked occupancy count.
//   clk, reset     : clock, synchronous active-high reset
//   push, din      : write request and data; ignored while full
//   pop            : read request; ignored while empty
//   dout           : head entry, valid while not empty
//   count          : occupancy, 0..DEPTH
//   full, empty    : occupancy flags
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic             do_push;
   logic             do_pop;

   // Acceptance looks at the occupancy before the edge, so a push against a
   // full FIFO is dropped even when a pop happens in the same cycle.
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign full    = count == CW'(DEPTH);
   assign empty   = count == '0;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         rd_ptr <= do_pop ? rd_ptr + AW'(1) : rd_ptr;
         wr_ptr <= do_push ? wr_ptr + AW'(1) : wr_ptr;
         count  <= count + CW'(do_push) - CW'(do_pop);
      end
   end

endmodule

// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: store-snooping UART transmitter, sends queued bytes as 8N1.
//   clk, reset           : clock, synchronous active-high reset
//   is_store, w_addr     : store strobe and address from the decoder/LSU
//   w_data_byte          : low byte of the store data
//   uart_tx              : registered serial line, idles high
//   tx_busy              : frame in flight or bytes queued
//   fifo_full, fifo_count: FIFO occupancy status
//   overflow             : one-cycle pulse after a dropped store
module uart_tx_mmio
   import uart_tx_mmio_pkg::*;
#(
   parameter int          CLKS_PER_BIT = 868,
   parameter int          FIFO_DEPTH   = 16,
   parameter logic [31:0] TX_ADDR      = UART_TX_ADDR
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          is_store,
   input  logic [31:0]                   w_addr,
   input  logic [7:0]                    w_data_byte,
   output logic                          uart_tx,
   output logic                          tx_busy,
   output logic                          fifo_full,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          overflow
);

   localparam int BW = $clog2(CLKS_PER_BIT);

   logic [1:0]    state;
   logic [BW-1:0] baud;
   logic [2:0]    idx;
   logic [7:0]    shift;
   logic [7:0]    head;
   logic          hit;
   logic          pop;
   logic          empty;
   logic          bit_end;

   assign hit     = is_store && w_addr == TX_ADDR;
   assign pop     = state == IDLE && !empty;
   assign bit_end = baud == BW'(CLKS_PER_BIT - 1);
   assign tx_busy = state != IDLE || fifo_count != '0;

   sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (hit),
      .pop   (pop),
      .din   (w_data_byte),
      .dout  (head),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (empty)
   );

   // uart_tx is loaded with the level of the state being entered, so the
   // line stays a pure register output.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         baud     <= '0;
         idx      <= '0;
         shift    <= '0;
         uart_tx  <= 1'b1;
         overflow <= 1'b0;
      end else begin
         overflow <= hit && fifo_full;
         baud     <= (state == IDLE || bit_end) ? '0 : baud + BW'(1);
         case (state)
            IDLE: if (pop) begin
               state   <= START;
               shift   <= head;
               uart_tx <= 1'b0;
            end
            START: if (bit_end) begin
               state   <= DATA;
               idx     <= '0;
               uart_tx <= shift[0];
            end
            DATA: if (bit_end) begin
               state   <= idx == 3'd7 ? STOP : DATA;
               idx     <= idx + 3'd1;
               shift   <= shift >> 1;
               uart_tx <= idx == 3'd7 ? 1'b1 : shift[1];
            end
            default: if (bit_end) begin
               state   <= IDLE;
               uart_tx <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb_uart_tx_mmio: directed self-checking bench for uart_tx_mmio (4 clocks/bit, 4-deep FIFO).
module tb_uart_tx_mmio;

   localparam logic [31:0] A = 32'h0000_8000;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        is_store = 1'b0;
   logic [31:0] w_addr = '0;
   logic [7:0]  w_data_byte = '0;
   logic        uart_tx;
   logic        tx_busy;
   logic        fifo_full;
   logic [2:0]  fifo_count;
   logic        overflow;

   int tests = 0;
   int fails = 0;
   int n;
   logic [7:0] bytes [6];

   uart_tx_mmio #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .is_store    (is_store),
      .w_addr      (w_addr),
      .w_data_byte (w_data_byte),
      .uart_tx     (uart_tx),
      .tx_busy     (tx_busy),
      .fifo_full   (fifo_full),
      .fifo_count  (fifo_count),
      .overflow    (overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One store cycle; returns at the negedge just after the store edge.
   task automatic store1(input logic [31:0] addr, input logic [7:0] d, input logic st);
      @(negedge clk);
      w_addr = addr; w_data_byte = d; is_store = st;
      @(negedge clk);
      is_store = 1'b0; w_addr = '0;
   endtask

   // Stores on consecutive edges; returns at the negedge after the last store edge.
   task automatic burst(input int cnt);
      for (int i = 0; i < cnt; i++) begin
         @(negedge clk);
         w_addr = A; w_data_byte = bytes[i]; is_store = 1'b1;
      end
      @(negedge clk);
      is_store = 1'b0; w_addr = '0;
   endtask

   task automatic wait_fall(input int budget, output int waited);
      waited = 0;
      while (uart_tx !== 1'b0 && waited < budget) begin
         @(negedge clk);
         waited++;
      end
   endtask

   // Current negedge is frame sample s0 (sample 0 = first start-bit cycle);
   // returns at the first negedge after the stop bit.
   task automatic frame(input logic [7:0] b, input int s0, input string tag);
      logic lvl;
      for (int s = s0; s < 40; s++) begin
         lvl = (s < 4) ? 1'b0 : (s < 36) ? b[(s - 4) / 4] : 1'b1;
         check($sformatf("%s_s%0d", tag, s), uart_tx, lvl);
         if (s == 39) check({tag, "_busy_end"}, tx_busy, 1);
         @(negedge clk);
      end
   endtask

   initial begin
      repeat (3) @(negedge clk);
      reset = 1'b0;
      check("rst_tx", uart_tx, 1);
      check("rst_busy", tx_busy, 0);
      check("rst_count", fifo_count, 0);
      check("rst_full", fifo_full, 0);
      check("rst_ovf", overflow, 0);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check($sformatf("idle_tx_%0d", i), uart_tx, 1);
         check($sformatf("idle_busy_%0d", i), tx_busy, 0);
         check($sformatf("idle_cnt_%0d", i), fifo_count, 0);
      end

      store1(A, 8'h55, 1'b1);
      check("s55_count", fifo_count, 1);
      check("s55_tx_pre", uart_tx, 1);
      wait_fall(10, n);
      check("s55_fall_lat", n, 1);
      frame(8'h55, 0, "f55");
      check("s55_busy_done", tx_busy, 0);
      check("s55_tx_done", uart_tx, 1);
      check("s55_cnt_done", fifo_count, 0);

      store1(A + 32'd4, 8'hA3, 1'b1);
      check("other_addr_cnt", fifo_count, 0);
      store1(A, 8'hA3, 1'b0);
      check("no_store_cnt", fifo_count, 0);
      wait_fall(20, n);
      check("ignored_no_frame", n, 20);
      check("ignored_busy", tx_busy, 0);

      bytes = '{8'h01, 8'h02, 8'h03, 8'h00, 8'h00, 8'h00};
      burst(3);
      check("b2b_count", fifo_count, 2);
      frame(8'h01, 1, "f01");
      wait_fall(10, n);
      check("b2b_gap1", n, 1);
      frame(8'h02, 0, "f02");
      wait_fall(10, n);
      check("b2b_gap2", n, 1);
      frame(8'h03, 0, "f03");
      check("b2b_busy_done", tx_busy, 0);

      bytes = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
      burst(6);
      check("ovf_pulse", overflow, 1);
      check("ovf_count", fifo_count, 4);
      check("ovf_full", fifo_full, 1);
      @(negedge clk);
      check("ovf_pulse_end", overflow, 0);
      check("ovf_count_hold", fifo_count, 4);
      frame(8'h10, 5, "f10");
      for (int k = 1; k < 5; k++) begin
         wait_fall(10, n);
         check($sformatf("ovf_gap%0d", k), n, 1);
         frame(8'h10 + 8'(k), 0, $sformatf("f1%0d", k));
      end
      wait_fall(60, n);
      check("ovf_dropped_never_sent", n, 60);
      check("ovf_cnt_done", fifo_count, 0);

      bytes = '{8'hFF, 8'hAA, 8'hBB, 8'h00, 8'h00, 8'h00};
      burst(3);
      check("rstf_count", fifo_count, 2);
      repeat (16) @(negedge clk);
      check("rstf_bit3", uart_tx, 1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("rstf_tx", uart_tx, 1);
      check("rstf_count", fifo_count, 0);
      check("rstf_busy", tx_busy, 0);
      check("rstf_full", fifo_full, 0);
      wait_fall(100, n);
      check("rstf_no_more_frames", n, 100);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
